// File: rtl/axi_err_slave_term.sv
// AXI4 slave terminator: accepts every burst, drains W data and answers each
// burst with a fixed error response, counting completions and capturing the first address.
module axi_err_slave_term #(
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned AXI_ID_WIDTH    = 7,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [1:0]  RESP            = 2'b11,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]   aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic                      w_last_i,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  output logic [AXI_ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]                b_resp_o,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]   ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]                ar_len_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [AXI_ID_WIDTH-1:0]   r_id_o,
  output logic [AXI_DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o,
  input  logic                      clr_i,
  output logic [CNT_WIDTH-1:0]      wr_err_cnt_o,
  output logic [CNT_WIDTH-1:0]      rd_err_cnt_o,
  output logic                      err_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0] err_addr_o,
  output logic                      err_is_write_o
);

  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_SEND} r_state_t;

  // ---------------- AW queue ----------------
  logic [AXI_ID_WIDTH-1:0] aw_id_mem [MAX_OUTSTANDING];
  logic [PW-1:0]           aw_wptr_reg, aw_rptr_reg;
  logic [CW-1:0]           aw_cnt_reg, aw_cnt_next;
  logic                    aw_ready_reg;
  logic                    aw_push, aw_pop;

  assign aw_push    = aw_valid_i && aw_ready_reg;
  assign aw_ready_o = aw_ready_reg;

  always_comb begin
    aw_cnt_next = aw_cnt_reg + CW'(aw_push) - CW'(aw_pop);
  end

  // Ready is registered from the next occupancy so no input reaches it combinationally.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      aw_wptr_reg  <= '0;
      aw_rptr_reg  <= '0;
      aw_cnt_reg   <= '0;
      aw_ready_reg <= 1'b0;
    end else begin
      if (aw_push) aw_wptr_reg <= aw_wptr_reg + PW'(1);
      if (aw_pop)  aw_rptr_reg <= aw_rptr_reg + PW'(1);
      aw_cnt_reg   <= aw_cnt_next;
      aw_ready_reg <= (aw_cnt_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_push) aw_id_mem[aw_wptr_reg] <= aw_id_i;
  end

  // ---------------- AR queue ----------------
  logic [AXI_ID_WIDTH-1:0] ar_id_mem  [MAX_OUTSTANDING];
  logic [7:0]              ar_len_mem [MAX_OUTSTANDING];
  logic [PW-1:0]           ar_wptr_reg, ar_rptr_reg;
  logic [CW-1:0]           ar_cnt_reg, ar_cnt_next;
  logic                    ar_ready_reg;
  logic                    ar_push, ar_pop;

  assign ar_push    = ar_valid_i && ar_ready_reg;
  assign ar_ready_o = ar_ready_reg;

  always_comb begin
    ar_cnt_next = ar_cnt_reg + CW'(ar_push) - CW'(ar_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ar_wptr_reg  <= '0;
      ar_rptr_reg  <= '0;
      ar_cnt_reg   <= '0;
      ar_ready_reg <= 1'b0;
    end else begin
      if (ar_push) ar_wptr_reg <= ar_wptr_reg + PW'(1);
      if (ar_pop)  ar_rptr_reg <= ar_rptr_reg + PW'(1);
      ar_cnt_reg   <= ar_cnt_next;
      ar_ready_reg <= (ar_cnt_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (ar_push) begin
      ar_id_mem[ar_wptr_reg]  <= ar_id_i;
      ar_len_mem[ar_wptr_reg] <= ar_len_i;
    end
  end

  // ---------------- Write FSM ----------------
  w_state_t                w_state_reg, w_state_next;
  logic [AXI_ID_WIDTH-1:0] b_id_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_reg <= W_IDLE;
      b_id_reg    <= '0;
    end else begin
      w_state_reg <= w_state_next;
      if (aw_pop) b_id_reg <= aw_id_mem[aw_rptr_reg];
    end
  end

  // Leaving IDLE on the push itself gives w_ready the cycle after AW is accepted.
  always_comb begin
    w_state_next = w_state_reg;
    aw_pop       = 1'b0;
    case (w_state_reg)
      W_IDLE:  if (aw_cnt_reg != '0 || aw_push) w_state_next = W_DRAIN;
      W_DRAIN: if (w_valid_i && w_last_i) begin
                 aw_pop       = 1'b1;
                 w_state_next = W_RESP;
               end
      W_RESP:  if (b_ready_i) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  assign w_ready_o = (w_state_reg == W_DRAIN);
  assign b_valid_o = (w_state_reg == W_RESP);
  assign b_id_o    = b_id_reg;
  assign b_resp_o  = RESP;

  // ---------------- Read FSM ----------------
  r_state_t   r_state_reg, r_state_next;
  logic [7:0] r_beat_reg, r_beat_next;
  logic       r_last;

  assign r_last = (r_state_reg == R_SEND) && (r_beat_reg == ar_len_mem[ar_rptr_reg]);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state_reg <= R_IDLE;
      r_beat_reg  <= '0;
    end else begin
      r_state_reg <= r_state_next;
      r_beat_reg  <= r_beat_next;
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    r_beat_next  = r_beat_reg;
    ar_pop       = 1'b0;
    case (r_state_reg)
      R_IDLE: if (ar_cnt_reg != '0 || ar_push) begin
                r_state_next = R_SEND;
                r_beat_next  = '0;
              end
      R_SEND: if (r_ready_i) begin
                if (r_last) begin
                  ar_pop       = 1'b1;
                  r_state_next = R_IDLE;
                end else begin
                  r_beat_next = r_beat_reg + 8'd1;
                end
              end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign r_valid_o = (r_state_reg == R_SEND);
  assign r_id_o    = ar_id_mem[ar_rptr_reg];
  assign r_data_o  = '0;
  assign r_resp_o  = RESP;
  assign r_last_o  = r_last;

  // ---------------- Counters and capture ----------------
  logic                      wr_inc, rd_inc, aw_hs, ar_hs;
  logic [CNT_WIDTH-1:0]      wr_cnt_reg, rd_cnt_reg;
  logic                      err_valid_reg, err_is_write_reg;
  logic [AXI_ADDR_WIDTH-1:0] err_addr_reg;

  assign wr_inc = b_valid_o && b_ready_i;
  assign rd_inc = r_valid_o && r_ready_i && r_last;
  assign aw_hs  = aw_push;
  assign ar_hs  = ar_push;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_cnt_reg <= '0;
      rd_cnt_reg <= '0;
    end else if (clr_i) begin
      wr_cnt_reg <= CNT_WIDTH'(wr_inc);
      rd_cnt_reg <= CNT_WIDTH'(rd_inc);
    end else begin
      if (wr_inc && wr_cnt_reg != '1) wr_cnt_reg <= wr_cnt_reg + CNT_WIDTH'(1);
      if (rd_inc && rd_cnt_reg != '1) rd_cnt_reg <= rd_cnt_reg + CNT_WIDTH'(1);
    end
  end

  // A handshake in the clearing cycle re-arms the capture with the new address.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_valid_reg    <= 1'b0;
      err_addr_reg     <= '0;
      err_is_write_reg <= 1'b0;
    end else if ((!err_valid_reg || clr_i) && (aw_hs || ar_hs)) begin
      err_valid_reg    <= 1'b1;
      err_addr_reg     <= aw_hs ? aw_addr_i : ar_addr_i;
      err_is_write_reg <= aw_hs;
    end else if (clr_i) begin
      err_valid_reg    <= 1'b0;
      err_addr_reg     <= '0;
      err_is_write_reg <= 1'b0;
    end
  end

  assign wr_err_cnt_o   = wr_cnt_reg;
  assign rd_err_cnt_o   = rd_cnt_reg;
  assign err_valid_o    = err_valid_reg;
  assign err_addr_o     = err_addr_reg;
  assign err_is_write_o = err_is_write_reg;

endmodule

// File: tb/tb_axi_err_slave_term.sv
// Directed bench for axi_err_slave_term with B/R scoreboards checked on each handshake.
module tb_axi_err_slave_term;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 7;
  localparam int CN = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          aw_valid_i, aw_ready_o;
  logic [IW-1:0] aw_id_i;
  logic [AW-1:0] aw_addr_i;
  logic          w_valid_i, w_ready_o, w_last_i;
  logic          b_valid_o, b_ready_i;
  logic [IW-1:0] b_id_o;
  logic [1:0]    b_resp_o;
  logic          ar_valid_i, ar_ready_o;
  logic [IW-1:0] ar_id_i;
  logic [AW-1:0] ar_addr_i;
  logic [7:0]    ar_len_i;
  logic          r_valid_o, r_ready_i;
  logic [IW-1:0] r_id_o;
  logic [DW-1:0] r_data_o;
  logic [1:0]    r_resp_o;
  logic          r_last_o;
  logic          clr_i;
  logic [CN-1:0] wr_err_cnt_o, rd_err_cnt_o;
  logic          err_valid_o;
  logic [AW-1:0] err_addr_o;
  logic          err_is_write_o;

  axi_err_slave_term #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
    .MAX_OUTSTANDING(4), .RESP(2'b11), .CNT_WIDTH(CN)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .clr_i(clr_i), .wr_err_cnt_o(wr_err_cnt_o), .rd_err_cnt_o(rd_err_cnt_o),
    .err_valid_o(err_valid_o), .err_addr_o(err_addr_o), .err_is_write_o(err_is_write_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [IW-1:0] id;
    logic          last;
  } rexp_t;

  logic [IW-1:0] exp_b[$];
  rexp_t         exp_r[$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_read(input logic [IW-1:0] id, input int len);
    rexp_t e;
    for (int i = 0; i <= len; i++) begin
      e.id   = id;
      e.last = (i == len);
      exp_r.push_back(e);
    end
  endtask

  // Scoreboard side: compare every B/R handshake and R stability under backpressure.
  logic          stall_prev = 1'b0;
  logic [IW-1:0] s_id;
  logic          s_last;

  always @(negedge clk_i) begin
    if (rst_ni && b_valid_o && b_ready_i) begin
      if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        chk("b_id", b_id_o, exp_b.pop_front());
        chk("b_resp", b_resp_o, 2'b11);
        $display("B  id=%0h resp=%0h", b_id_o, b_resp_o);
      end
    end
    if (rst_ni && stall_prev)
      chk("r_stable", {r_valid_o, r_id_o, r_last_o, r_data_o == '0, r_resp_o},
          {1'b1, s_id, s_last, 1'b1, 2'b11});
    if (rst_ni && r_valid_o && r_ready_i) begin
      if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        rexp_t e;
        e = exp_r.pop_front();
        chk("r_id", r_id_o, e.id);
        chk("r_last", r_last_o, e.last);
        chk("r_data", r_data_o, 64'h0);
        chk("r_resp", r_resp_o, 2'b11);
        $display("R  id=%0h last=%0b data=%0h", r_id_o, r_last_o, r_data_o);
      end
    end
    stall_prev = rst_ni && r_valid_o && !r_ready_i;
    s_id       = r_id_o;
    s_last     = r_last_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_ni = 1'b0; aw_valid_i = 0; aw_id_i = '0; aw_addr_i = '0;
    w_valid_i = 0; w_last_i = 0; b_ready_i = 0;
    ar_valid_i = 0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0;
    r_ready_i = 0; clr_i = 0;

    // Reset state
    tick(); tick();
    chk("rst_aw_ready", aw_ready_o, 0);
    chk("rst_ar_ready", ar_ready_o, 0);
    chk("rst_valids", {b_valid_o, r_valid_o, w_ready_o}, 3'b000);
    chk("rst_cnts", {wr_err_cnt_o, rd_err_cnt_o}, 4'h0);
    chk("rst_err", {err_valid_o, err_is_write_o, err_addr_o}, 34'h0);
    rst_ni = 1'b1;
    tick();
    chk("rel_ready", {aw_ready_o, ar_ready_o}, 2'b11);

    // W before any AW is stalled
    w_valid_i = 1; w_last_i = 1;
    tick();
    chk("w_stall_no_aw", w_ready_o, 0);
    w_valid_i = 0; w_last_i = 0;

    // Single 4-beat write
    aw_valid_i = 1; aw_id_i = 7'h15; aw_addr_i = 32'h1000_0040; b_ready_i = 1;
    exp_b.push_back(7'h15);
    tick();
    aw_valid_i = 0;
    chk("w_ready_lat", w_ready_o, 1);
    w_valid_i = 1;
    tick(); tick(); tick();
    chk("b_not_early", b_valid_o, 0);
    w_last_i = 1;
    tick();
    w_valid_i = 0; w_last_i = 0;
    chk("b_valid_lat", b_valid_o, 1);
    chk("b_id_direct", b_id_o, 7'h15);
    tick();
    chk("b_done", b_valid_o, 0);
    chk("wr_cnt_1", wr_err_cnt_o, 1);
    chk("cap_write", {err_valid_o, err_is_write_o, err_addr_o}, {2'b11, 32'h1000_0040});

    // 8-beat read with toggling r_ready
    ar_valid_i = 1; ar_id_i = 7'h3; ar_addr_i = 32'h2000_0000; ar_len_i = 8'd7; r_ready_i = 0;
    push_read(7'h3, 7);
    tick();
    ar_valid_i = 0;
    chk("r_valid_lat", r_valid_o, 1);
    for (int c = 0; c < 40 && exp_r.size() > 0; c++) begin
      r_ready_i = ~r_ready_i;
      tick();
    end
    r_ready_i = 0;
    chk("r_burst_done", exp_r.size(), 0);
    chk("r_idle_after", r_valid_o, 0);
    chk("rd_cnt_1", rd_err_cnt_o, 1);
    chk("cap_kept", err_addr_o, 32'h1000_0040);

    clr_i = 1; tick(); clr_i = 0;
    chk("clr1", {err_valid_o, wr_err_cnt_o, rd_err_cnt_o}, 5'h0);

    // Simultaneous AW/AR as first accesses after clear
    aw_valid_i = 1; aw_id_i = 7'h1; aw_addr_i = 32'hA0;
    ar_valid_i = 1; ar_id_i = 7'h2; ar_addr_i = 32'hB0; ar_len_i = 8'd0;
    r_ready_i = 1; b_ready_i = 1; w_valid_i = 1; w_last_i = 1;
    exp_b.push_back(7'h1);
    push_read(7'h2, 0);
    tick();
    aw_valid_i = 0; ar_valid_i = 0;
    chk("cap_aw_wins", {err_valid_o, err_is_write_o, err_addr_o}, {2'b11, 32'hA0});
    tick();
    w_valid_i = 0; w_last_i = 0;
    for (int c = 0; c < 20 && (exp_b.size() > 0 || exp_r.size() > 0); c++) tick();
    chk("both_done", exp_b.size() + exp_r.size(), 0);
    chk("cnt_both", {wr_err_cnt_o, rd_err_cnt_o}, 4'b0101);
    clr_i = 1; tick(); clr_i = 0;
    chk("clr2", {err_valid_o, wr_err_cnt_o, rd_err_cnt_o}, 5'h0);

    // AW backpressure with no W data
    n = 0;
    aw_valid_i = 1; aw_id_i = 7'h1; aw_addr_i = 32'h400;
    for (int c = 0; c < 8; c++) begin
      if (aw_ready_o) begin
        exp_b.push_back(aw_id_i);
        n++;
        tick();
        aw_id_i = IW'(n + 1);
      end else tick();
    end
    chk("aw_accepts", n, 4);
    chk("aw_full", aw_ready_o, 0);
    w_valid_i = 1; w_last_i = 1;
    tick();
    w_valid_i = 0; w_last_i = 0;
    for (int c = 0; c < 10 && !aw_ready_o; c++) tick();
    chk("aw_reopen", aw_ready_o, 1);
    exp_b.push_back(aw_id_i);
    tick();
    aw_valid_i = 0;
    w_valid_i = 1; w_last_i = 1;
    for (int c = 0; c < 60 && exp_b.size() > 0; c++) tick();
    w_valid_i = 0; w_last_i = 0;
    chk("bp_done", exp_b.size(), 0);
    chk("wr_sat", wr_err_cnt_o, 3);

    // Read counter saturation: five single-beat reads
    n = 0;
    ar_valid_i = 1; ar_id_i = 7'h10; ar_len_i = 8'd0; r_ready_i = 1;
    for (int c = 0; c < 30 && n < 5; c++) begin
      if (ar_ready_o) begin
        push_read(ar_id_i, 0);
        n++;
        tick();
        ar_id_i = IW'(7'h10 + n);
      end else tick();
    end
    ar_valid_i = 0;
    for (int c = 0; c < 30 && exp_r.size() > 0; c++) tick();
    chk("sat_reads_done", exp_r.size(), 0);
    chk("rd_sat", rd_err_cnt_o, 3);

    // clr together with a B handshake
    b_ready_i = 0;
    aw_valid_i = 1; aw_id_i = 7'h22; aw_addr_i = 32'h300;
    exp_b.push_back(7'h22);
    tick();
    aw_valid_i = 0; w_valid_i = 1; w_last_i = 1;
    tick();
    w_valid_i = 0; w_last_i = 0;
    for (int c = 0; c < 10 && !b_valid_o; c++) tick();
    chk("b_wait", b_valid_o, 1);
    clr_i = 1; b_ready_i = 1;
    tick();
    clr_i = 0;
    chk("clr_with_b", {wr_err_cnt_o, rd_err_cnt_o}, 4'b0100);
    chk("clr_err", err_valid_o, 0);

    // clr together with an AR handshake: new capture wins
    ar_valid_i = 1; ar_id_i = 7'h33; ar_addr_i = 32'hC0; ar_len_i = 8'd0; clr_i = 1;
    push_read(7'h33, 0);
    tick();
    ar_valid_i = 0; clr_i = 0;
    chk("clr_cap", {err_valid_o, err_is_write_o, err_addr_o}, {2'b10, 32'hC0});
    for (int c = 0; c < 10 && exp_r.size() > 0; c++) tick();
    chk("rd_after_clr", rd_err_cnt_o, 1);

    // Reset in the middle of an 8-beat read
    ar_valid_i = 1; ar_id_i = 7'h9; ar_len_i = 8'd7; r_ready_i = 1;
    push_read(7'h9, 7);
    tick();
    ar_valid_i = 0;
    tick(); tick(); tick();
    rst_ni = 0;
    exp_r.delete();
    tick();
    chk("mid_rst_rvalid", r_valid_o, 0);
    chk("mid_rst_ready", {aw_ready_o, ar_ready_o}, 2'b00);
    chk("mid_rst_cnt", rd_err_cnt_o, 0);
    rst_ni = 1;
    tick();
    chk("post_rst", {ar_ready_o, r_valid_o}, 2'b10);
    ar_valid_i = 1; ar_id_i = 7'hA; ar_len_i = 8'd2;
    push_read(7'hA, 2);
    tick();
    ar_valid_i = 0;
    for (int c = 0; c < 20 && exp_r.size() > 0; c++) tick();
    chk("post_rst_burst", exp_r.size(), 0);
    chk("post_rst_cnt", rd_err_cnt_o, 1);
    chk("b_queue_empty", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_err_slave_term.md
Name: axi_err_slave_term

Overview:
- Synthesizable AXI4 slave terminator for unused RAB ports (ACP, SoC-bus return path, spare slave ports).
- Accepts any burst protocol-correctly, drains write data and returns B/R responses with matching ID and a programmable error response.
- Counts terminated transactions and captures the first offending address for debug/interrupt.
- Replaces permanently-ready tie-offs, which would hang any initiator waiting for responses.

Parameters:
- AXI_ADDR_WIDTH, 32, address width (capture only).
- AXI_DATA_WIDTH, 64, R data width; W data is ignored.
- AXI_ID_WIDTH, 7, ID width echoed on B/R.
- MAX_OUTSTANDING, 4, depth of each AW and AR queue; power of 2, ≥2.
- RESP, 2'b11, response code on B and R (DECERR).
- CNT_WIDTH, 16, width of the error counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- aw_valid_i / aw_ready_o  in/out  1  AW handshake.
- aw_id_i  in  AXI_ID_WIDTH.
- aw_addr_i  in  AXI_ADDR_WIDTH.
- w_valid_i / w_ready_o  in/out  1  W handshake.
- w_last_i  in  1.
- b_valid_o / b_ready_i  out/in  1  B handshake.
- b_id_o  out  AXI_ID_WIDTH.
- b_resp_o  out  2.
- ar_valid_i / ar_ready_o  in/out  1  AR handshake.
- ar_id_i  in  AXI_ID_WIDTH.
- ar_addr_i  in  AXI_ADDR_WIDTH.
- ar_len_i  in  8.
- r_valid_o / r_ready_i  out/in  1  R handshake.
- r_id_o  out  AXI_ID_WIDTH.
- r_data_o  out  AXI_DATA_WIDTH.
- r_resp_o  out  2.
- r_last_o  out  1.
- clr_i  in  1  clears counters and the capture.
- wr_err_cnt_o  out  CNT_WIDTH  completed write bursts.
- rd_err_cnt_o  out  CNT_WIDTH  completed read bursts.
- err_valid_o  out  1  sticky first-error flag (interrupt).
- err_addr_o  out  AXI_ADDR_WIDTH  address of first AW/AR accepted while err_valid_o=0.
- err_is_write_o  out  1  1 = captured address came from AW.

Behaviour:
- Reset (rst_ni=0 at posedge): queues flushed, FSMs to IDLE, all valids 0, counters 0, err_* 0.
  - aw_ready_o/ar_ready_o are 0 during reset and 1 from the first cycle after release.
  - Reset mid-burst abandons the burst silently.
- AW queue: stores id. aw_ready_o = !full; registered, so no combinational path from any input.
- AR queue: stores {id, len}. ar_ready_o = !full.
- Write FSM:
  - W_IDLE: w_ready_o=0. Go to W_DRAIN when the AW queue is non-empty. W beats arriving before their AW are stalled.
  - W_DRAIN: w_ready_o=1. On a handshake with w_last_i=1, pop AW and go to W_RESP.
  - W_RESP: b_valid_o=1, b_id_o=popped id, b_resp_o=RESP. Hold stable until b_ready_i, then return to W_IDLE.
- Write latency: AW accepted cycle N → earliest w_ready_o at N+1. W last beat accepted at M → b_valid_o at M+1.
- Read FSM:
  - R_IDLE: go to R_SEND when the AR queue is non-empty; load beat counter = 0.
  - R_SEND: r_valid_o=1, r_id_o=head id, r_data_o=0, r_resp_o=RESP, r_last_o=(cnt==len).
  - On each handshake cnt++. On the last handshake, pop AR and go to R_IDLE.
  - All R outputs hold stable while r_valid_o && !r_ready_i.
- Read latency: AR accepted cycle N → r_valid_o at N+1.
- Read and write paths are fully independent; bursts are served in order within each path.
- Counters:
  - Increment on a B handshake (write) or an R handshake with r_last_o (read).
  - Saturate at all-ones.
  - clr_i zeroes them; a same-cycle increment with clr_i yields 1.
- Capture:
  - On an AW or AR handshake while err_valid_o=0, latch the address and set err_valid_o.
  - AW and AR in the same cycle → AW wins (err_is_write_o=1).
  - clr_i together with a handshake → the new capture wins.
- ar_len_i up to 255 (256 beats) supported. Burst type and size are ignored.

Test Plan:
- Write: AW id=0x15 addr=0x1000_0040, 4 W beats, b_ready=1 → b_valid one cycle after last W, b_id=0x15, b_resp=2'b11; wr_err_cnt=1; err_valid=1, err_addr=0x1000_0040, err_is_write=1.
- Read: AR id=0x3 len=7 with r_ready toggling 1/0 → exactly 8 R beats, r_last only on the 8th, r_data=0, outputs stable while stalled; rd_err_cnt=1.
- Backpressure: 5 AWs back-to-back, no W, MAX_OUTSTANDING=4 → aw_ready_o drops after the 4th accept. Completing one burst reopens it; B ids return in issue order.
- Same-cycle AW addr=0xA0 and AR addr=0xB0 as the first accesses → err_addr=0xA0, err_is_write=1. clr_i then clears err_valid and both counters to 0.
- Saturation with CNT_WIDTH=2: 5 reads → rd_err_cnt stays 3. clr_i together with a final B handshake → wr_err_cnt=1.
- Reset asserted mid read burst (beat 3 of 8) → next cycle r_valid=0, queues empty. A new AR after release starts at beat 0.
